dac_spi_tx: RTL and testbench

Serial transmitter that drives processed samples out to the 10-bit SPI DAC (MCP4911-style 16-bit write frame). It is the output end of the sample path: it accepts one parallel sample per `load` strobe, the same strobe-per-sample convention the ADC side and the RAM delay line use. It serialises the sample MSB-first with a programmable SCK rate, then pulses LDAC so the analogue output updates once per frame.

---
 rtl/dac_spi_tx.sv | 165 ++++++++++++++++
 tb/tb_dac_spi_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// Serialises 10-bit samples into 16-bit MCP4911-style frames on SPI, then strobes LDAC.
// Build option: DAC_TX_PENDING_EN adds a one-deep pending sample register.
//
// state | meaning
// IDLE  | waiting for load, CS high, SDI low
// SETUP | CS low, SDI holds frame bit 15 ahead of the first SCK rise
// SHIFT | SCK toggles every CLK_DIV cycles; SDI advances on each fall
// GAP   | CS high again, SCK low, before the latch strobe
// LATCH | LDAC low; done pulses in the last cycle
module dac_spi_tx #(
   parameter int CLK_DIV = 25,
   parameter bit BUF_BIT = 1'b0,
   parameter bit GA_N    = 1'b1
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic [9:0] d,
   input  logic       load,
   output logic       dac_cs_n,
   output logic       dac_sck,
   output logic       dac_sdi,
   output logic       dac_ldac_n,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, LATCH} state_t;

   localparam logic [7:0] HP_RELOAD = 8'(CLK_DIV - 1);

   state_t      state;
   logic [7:0]  hcnt;
   logic [4:0]  bitcnt;
   logic [15:0] shreg;
   logic        start;
   logic [9:0]  start_d;
   logic [15:0] start_word;

`ifdef DAC_TX_PENDING_EN
   logic       pend_valid;
   logic [9:0] pend_d;
   logic       take_pend;
`endif

   always_comb begin
      start   = 1'b0;
      start_d = d;
`ifdef DAC_TX_PENDING_EN
      take_pend = 1'b0;
      if (pend_valid && (state == IDLE || (state == LATCH && hcnt == 8'd0))) begin
         start     = 1'b1;
         start_d   = pend_d;
         take_pend = 1'b1;
      end else if (state == IDLE && load) begin
         start = 1'b1;
      end
`else
      if (state == IDLE && load) start = 1'b1;
`endif
      start_word = {1'b0, BUF_BIT, GA_N, 1'b1, start_d, 2'b00};
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state      <= IDLE;
         hcnt       <= 8'd0;
         bitcnt     <= 5'd0;
         shreg      <= 16'd0;
         dac_cs_n   <= 1'b1;
         dac_sck    <= 1'b0;
         dac_sdi    <= 1'b0;
         dac_ldac_n <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
`ifdef DAC_TX_PENDING_EN
         pend_valid <= 1'b0;
         pend_d     <= 10'd0;
`endif
      end else begin
         done <= 1'b0;
         if (start) begin
            state      <= SETUP;
            hcnt       <= HP_RELOAD;
            bitcnt     <= 5'd15;
            shreg      <= start_word;
            dac_sdi    <= start_word[15];
            dac_cs_n   <= 1'b0;
            dac_sck    <= 1'b0;
            dac_ldac_n <= 1'b1;
            busy       <= 1'b1;
         end else begin
            case (state)
               IDLE: ;
               SETUP: begin
                  if (hcnt == 8'd0) begin
                     state   <= SHIFT;
                     hcnt    <= HP_RELOAD;
                     dac_sck <= 1'b1;
                  end else begin
                     hcnt <= hcnt - 8'd1;
                  end
               end
               SHIFT: begin
                  if (hcnt == 8'd0) begin
                     hcnt <= HP_RELOAD;
                     if (!dac_sck) begin
                        dac_sck <= 1'b1;
                     end else begin
                        dac_sck <= 1'b0;
                        if (bitcnt == 5'd0) begin
                           state    <= GAP;
                           dac_cs_n <= 1'b1;
                        end else begin
                           bitcnt  <= bitcnt - 5'd1;
                           dac_sdi <= shreg[14];
                           shreg   <= {shreg[14:0], 1'b0};
                        end
                     end
                  end else begin
                     hcnt <= hcnt - 8'd1;
                  end
               end
               GAP: begin
                  if (hcnt == 8'd0) begin
                     state      <= LATCH;
                     hcnt       <= HP_RELOAD;
                     dac_ldac_n <= 1'b0;
                     done       <= (CLK_DIV == 1);
                  end else begin
                     hcnt <= hcnt - 8'd1;
                  end
               end
               LATCH: begin
                  if (hcnt == 8'd0) begin
                     state      <= IDLE;
                     dac_ldac_n <= 1'b1;
                     busy       <= 1'b0;
                     dac_sdi    <= 1'b0;
                  end else begin
                     hcnt <= hcnt - 8'd1;
                     done <= (hcnt == 8'd1);
                  end
               end
               default: state <= IDLE;
            endcase
         end

`ifdef DAC_TX_PENDING_EN
         // A load that cannot start a frame right now is parked; overwriting a live one loses a sample.
         if (load && !(start && !take_pend)) begin
            pend_d     <= d;
            pend_valid <= 1'b1;
            if (pend_valid && !take_pend) overrun <= 1'b1;
         end else if (take_pend) begin
            pend_valid <= 1'b0;
         end
`else
         if (load && state != IDLE) overrun <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV 2 and 25) checked cycle by cycle
// against a frame-timing model derived from the frame arithmetic.
module tb_dac_spi_tx;

   localparam int D0 = 2;
   localparam int D1 = 25;

   logic       sysclk = 1'b0;
   logic       rst;
   logic       ld [2];
   logic [9:0] dd [2];
   logic       cs_n [2];
   logic       sck [2];
   logic       sdi [2];
   logic       ldac_n [2];
   logic       bsy [2];
   logic       dn [2];
   logic       ov [2];

   int checks = 0;
   int errors = 0;

   always #5 sysclk = ~sysclk;

   dac_spi_tx #(.CLK_DIV(D0)) u_dut0 (
      .sysclk(sysclk), .reset(rst), .d(dd[0]), .load(ld[0]),
      .dac_cs_n(cs_n[0]), .dac_sck(sck[0]), .dac_sdi(sdi[0]), .dac_ldac_n(ldac_n[0]),
      .busy(bsy[0]), .done(dn[0]), .overrun(ov[0]));

   dac_spi_tx #(.CLK_DIV(D1)) u_dut1 (
      .sysclk(sysclk), .reset(rst), .d(dd[1]), .load(ld[1]),
      .dac_cs_n(cs_n[1]), .dac_sck(sck[1]), .dac_sdi(sdi[1]), .dac_ldac_n(ldac_n[1]),
      .busy(bsy[1]), .done(dn[1]), .overrun(ov[1]));

   function automatic logic [15:0] fword(input logic [9:0] v);
      return {1'b0, 1'b0, 1'b1, 1'b1, v, 2'b00};
   endfunction

   // {cs_n, sck, sdi, ldac_n, busy, done} at cycle t after T0 of one frame
   function automatic logic [5:0] fvec(input int t, input int dv, input logic [15:0] w);
      logic c, s, q, l;
      int k;
      if (t < 0 || t >= 34 * dv) return 6'b100100;
      c = (t >= 32 * dv);
      s = (t >= dv) && (t < 33 * dv) && ((((t - dv) / dv) % 2) == 0);
      k = t / (2 * dv);
      if (k > 15) k = 15;
      q = w[15 - k];
      l = !(t >= 33 * dv);
      return {c, s, q, l, 1'b1, (t == 34 * dv - 1)};
   endfunction

   function automatic logic [5:0] obsv(input int idx);
      return {cs_n[idx], sck[idx], sdi[idx], ldac_n[idx], bsy[idx], dn[idx]};
   endfunction

   task automatic send(input int idx, input logic [9:0] v);
      @(posedge sysclk); #1;
      ld[idx] = 1'b1;
      dd[idx] = v;
      @(posedge sysclk); #1;
      ld[idx] = 1'b0;
   endtask

   task automatic watch(input int idx, input int dv, input int ncyc, input int off2,
                        input int it0, input logic [9:0] iv0,
                        input int it1, input logic [9:0] iv1,
                        input logic [15:0] w1, input logic [15:0] w2, input int nwords);
      logic [5:0]  o, e;
      logic [15:0] cap;
      logic [15:0] caps [4];
      logic        psck;
      int          nb, ncap;
      psck = 1'b0; nb = 0; ncap = 0; cap = 16'd0;
      for (int i = 0; i < 4; i++) caps[i] = 16'hxxxx;
      for (int t = 0; t < ncyc; t++) begin
         @(negedge sysclk);
         o = obsv(idx);
         if (off2 > 0 && t >= off2) e = fvec(t - off2, dv, w2);
         else e = fvec(t, dv, w1);
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL wave inst%0d t=%0d observed=%b expected=%b", idx, t, o, e);
         end
         if (sck[idx] && !psck) begin
            cap = {cap[14:0], sdi[idx]};
            nb++;
            if (nb == 16) begin
               if (ncap < 4) caps[ncap] = cap;
               ncap++;
               nb = 0;
            end
         end
         psck = sck[idx];
         if (t == it0) begin ld[idx] = 1'b1; dd[idx] = iv0; end
         else if (t == it1) begin ld[idx] = 1'b1; dd[idx] = iv1; end
         else ld[idx] = 1'b0;
      end
      ld[idx] = 1'b0;
      checks++;
      assert (ncap === nwords) else begin
         errors++;
         $error("FAIL nframes inst%0d observed=%0d expected=%0d", idx, ncap, nwords);
      end
      checks++;
      assert (caps[0] === w1) else begin
         errors++;
         $error("FAIL word1 inst%0d observed=%h expected=%h", idx, caps[0], w1);
      end
      if (nwords > 1) begin
         checks++;
         assert (caps[1] === w2) else begin
            errors++;
            $error("FAIL word2 inst%0d observed=%h expected=%h", idx, caps[1], w2);
         end
      end
   endtask

   task automatic chk_ov(input int idx, input logic exp_ov);
      checks++;
      assert (ov[idx] === exp_ov) else begin
         errors++;
         $error("FAIL overrun inst%0d observed=%b expected=%b", idx, ov[idx], exp_ov);
      end
   endtask

   initial begin
      logic [9:0] v, v2;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin ld[i] = 1'b0; dd[i] = 10'd0; end
      // load held with reset must be discarded
      @(posedge sysclk); #1; ld[0] = 1'b1; dd[0] = 10'h155;
      repeat (3) @(posedge sysclk);
      #1; ld[0] = 1'b0; rst = 1'b0;
      @(negedge sysclk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         assert (obsv(i) === 6'b100100) else begin
            errors++;
            $error("FAIL reset inst%0d observed=%b expected=%b", i, obsv(i), 6'b100100);
         end
         chk_ov(i, 1'b0);
      end

      // reference frame and default divider
      send(0, 10'h2A5);
      watch(0, D0, 34 * D0 + 6, 0, -1, 10'd0, -1, 10'd0, 16'h3A94, 16'h0, 1);
      chk_ov(0, 1'b0);
      send(1, 10'h3FF);
      watch(1, D1, 34 * D1 + 4, 0, -1, 10'd0, -1, 10'd0, 16'h3FFC, 16'h0, 1);
      v = 10'($urandom);
      send(1, v);
      watch(1, D1, 34 * D1 + 2, 0, -1, 10'd0, -1, 10'd0, fword(v), 16'h0, 1);
      chk_ov(1, 1'b0);

      // load in the first cycle busy is low starts the next frame one cycle later
      v  = 10'($urandom);
      v2 = 10'($urandom);
      send(0, v);
      watch(0, D0, 2 * 34 * D0 + 4, 34 * D0 + 1, 34 * D0, v2, -1, 10'd0, fword(v), fword(v2), 2);
      chk_ov(0, 1'b0);

      // reset mid-frame aborts without an LDAC pulse
      send(0, 10'h0F3);
      for (int t = 0; t <= 20; t++) begin
         @(negedge sysclk);
         if (t == 20) rst = 1'b1;
      end
      @(negedge sysclk);
      rst = 1'b0;
      checks++;
      assert (obsv(0) === 6'b100100) else begin
         errors++;
         $error("FAIL abort observed=%b expected=%b", obsv(0), 6'b100100);
      end
      for (int t = 0; t < 4 * D0 * 34; t++) begin
         @(negedge sysclk);
         checks++;
         assert (obsv(0) === 6'b100100) else begin
            errors++;
            $error("FAIL post_abort t=%0d observed=%b expected=%b", t, obsv(0), 6'b100100);
         end
      end
      chk_ov(0, 1'b0);

      // random samples after the abort must come out clean
      for (int i = 0; i < 3; i++) begin
         v = 10'($urandom);
         send(0, v);
         watch(0, D0, 34 * D0 + 3, 0, -1, 10'd0, -1, 10'd0, fword(v), 16'h0, 1);
      end
      chk_ov(0, 1'b0);

`ifdef DAC_TX_PENDING_EN
      send(0, 10'h100);
      watch(0, D0, 2 * 34 * D0 + 4, 34 * D0, 5, 10'h200, -1, 10'd0, 16'h3400, 16'h3800, 2);
      chk_ov(0, 1'b0);
      v  = 10'($urandom);
      v2 = 10'($urandom);
      send(0, v);
      watch(0, D0, 2 * 34 * D0 + 4, 34 * D0, 5, 10'h0F0, 7, v2, fword(v), fword(v2), 2);
      chk_ov(0, 1'b1);
`else
      send(0, 10'h2A5);
      watch(0, D0, 3 * 34 * D0, 0, 10, 10'h001, -1, 10'd0, 16'h3A94, 16'h0, 1);
      chk_ov(0, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout");
      $fatal(1, "bench time limit reached");
   end

endmodule
